// File: rtl/tlb_cp0_ctrl_if.sv
// Bus between the CP0 TLB controller and its environment.
// Carries the instruction handshake, CP0 access, and the TLB search/read/write ports.
interface tlb_cp0_ctrl_if #(
    parameter int unsigned TLBNUM = 16
);
    localparam int unsigned IW = $clog2(TLBNUM);

    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready;
    logic          op_done;

    logic          mtc0_we;
    logic [7:0]    mtc0_addr;
    logic [31:0]   mtc0_wdata;
    logic [7:0]    mfc0_addr;
    logic [31:0]   mfc0_rdata;

    logic [18:0]   s1_vpn2;
    logic          s1_odd_page;
    logic [7:0]    s1_asid;
    logic          s1_found;
    logic [IW-1:0] s1_index;

    logic          we;
    logic [IW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0;
    logic [19:0]   w_pfn1;
    logic [2:0]    w_c0;
    logic [2:0]    w_c1;
    logic          w_d0;
    logic          w_d1;
    logic          w_v0;
    logic          w_v1;

    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0;
    logic [19:0]   r_pfn1;
    logic [2:0]    r_c0;
    logic [2:0]    r_c1;
    logic          r_d0;
    logic          r_d1;
    logic          r_v0;
    logic          r_v1;

    // Environment side: CPU pipeline plus the TLB array
    modport master (
        output op_valid, op_type, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        output s1_found, s1_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_pfn1, r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
        input  op_ready, op_done, mfc0_rdata, s1_vpn2, s1_odd_page, s1_asid,
        input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1, w_c0, w_c1,
        input  w_d0, w_d1, w_v0, w_v1, r_index
    );

    modport slave (
        input  op_valid, op_type, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
        input  s1_found, s1_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_pfn1, r_c0, r_c1, r_d0, r_d1, r_v0, r_v1,
        output op_ready, op_done, mfc0_rdata, s1_vpn2, s1_odd_page, s1_asid,
        output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_pfn1, w_c0, w_c1,
        output w_d0, w_d1, w_v0, w_v1, r_index
    );
endinterface

// File: rtl/tlb_cp0_ctrl.sv
// CP0 Index/EntryHi/EntryLo0/EntryLo1 registers and the TLBP/TLBR/TLBWI sequencer.
// Every TLB op takes a fixed IDLE -> op -> DONE -> IDLE path.
module tlb_cp0_ctrl #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic          clk,
    input  logic          reset,
    tlb_cp0_ctrl_if.slave bus
);
    localparam int unsigned IW = $clog2(TLBNUM);

    localparam logic [7:0] ADDR_INDEX = 8'h00;
    localparam logic [7:0] ADDR_LO0   = 8'h10;
    localparam logic [7:0] ADDR_LO1   = 8'h18;
    localparam logic [7:0] ADDR_HI    = 8'h50;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;

    logic          idx_p;
    logic [IW-1:0] idx;
    logic [18:0]   hi_vpn2;
    logic [7:0]    hi_asid;
    logic [25:0]   lo0;   // {PFN, C, D, V, G}
    logic [25:0]   lo1;

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op_type)
                        OP_TLBP:  next_state = S_PROBE;
                        OP_TLBR:  next_state = S_READ;
                        OP_TLBWI: next_state = S_WRITE;
                        default:  next_state = S_DONE;
                    endcase
                end
            end
            S_PROBE, S_READ, S_WRITE: next_state = S_DONE;
            S_DONE:                   next_state = S_IDLE;
            default:                  next_state = S_IDLE;
        endcase
    end

    // State register; status outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            bus.op_ready <= 1'b1;
            bus.op_done  <= 1'b0;
            bus.we       <= 1'b0;
        end else begin
            state        <= next_state;
            bus.op_ready <= (next_state == S_IDLE);
            bus.op_done  <= (next_state == S_DONE);
            bus.we       <= (next_state == S_WRITE);
        end
    end

    // CP0 register file: mtc0 only while idle, probe/read results at the end of their cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_p   <= 1'b0;
            idx     <= '0;
            hi_vpn2 <= '0;
            hi_asid <= '0;
            lo0     <= '0;
            lo1     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mtc0_we) begin
                        case (bus.mtc0_addr)
                            ADDR_INDEX: idx <= bus.mtc0_wdata[IW-1:0];
                            ADDR_LO0:   lo0 <= bus.mtc0_wdata[25:0];
                            ADDR_LO1:   lo1 <= bus.mtc0_wdata[25:0];
                            ADDR_HI: begin
                                hi_vpn2 <= bus.mtc0_wdata[31:13];
                                hi_asid <= bus.mtc0_wdata[7:0];
                            end
                            default: ;
                        endcase
                    end
                end
                S_PROBE: begin
                    idx_p <= ~bus.s1_found;
                    if (bus.s1_found) begin
                        idx <= bus.s1_index;
                    end
                end
                S_READ: begin
                    hi_vpn2 <= bus.r_vpn2;
                    hi_asid <= bus.r_asid;
                    lo0     <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
                    lo1     <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
                end
                default: ;
            endcase
        end
    end

    // Combinational mfc0 read port
    always_comb begin
        bus.mfc0_rdata = 32'h0;
        case (bus.mfc0_addr)
            ADDR_INDEX: bus.mfc0_rdata = {idx_p, {(31 - IW){1'b0}}, idx};
            ADDR_LO0:   bus.mfc0_rdata = {6'b0, lo0};
            ADDR_LO1:   bus.mfc0_rdata = {6'b0, lo1};
            ADDR_HI:    bus.mfc0_rdata = {hi_vpn2, 5'b0, hi_asid};
            default:    bus.mfc0_rdata = 32'h0;
        endcase
    end

    assign bus.s1_vpn2     = hi_vpn2;
    assign bus.s1_asid     = hi_asid;
    assign bus.s1_odd_page = 1'b0;
    assign bus.r_index     = idx;

    assign bus.w_index = idx;
    assign bus.w_vpn2  = hi_vpn2;
    assign bus.w_asid  = hi_asid;
    assign bus.w_g     = lo0[0] & lo1[0];
    assign bus.w_pfn0  = lo0[25:6];
    assign bus.w_c0    = lo0[5:3];
    assign bus.w_d0    = lo0[2];
    assign bus.w_v0    = lo0[1];
    assign bus.w_pfn1  = lo1[25:6];
    assign bus.w_c1    = lo1[5:3];
    assign bus.w_d1    = lo1[2];
    assign bus.w_v1    = lo1[1];
endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Bench for tlb_cp0_ctrl: a 16-entry TLB array as environment, CP0 registers modelled
// as plain 32-bit words, directed checks followed by randomized mtc0/op sequences.
module tb_tlb_cp0_ctrl;
    localparam logic [1:0] T_P  = 2'd0;
    localparam logic [1:0] T_R  = 2'd1;
    localparam logic [1:0] T_WI = 2'd2;
    localparam logic [1:0] T_RS = 2'd3;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    tlb_cp0_ctrl_if #(.TLBNUM(16)) bus ();
    tlb_cp0_ctrl #(.TLBNUM(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    ent_t tlb [16] = '{default: '0};
    ent_t re;

    // CP0 model as architectural 32-bit words
    logic [31:0] m_index = '0, m_hi = '0, m_lo0 = '0, m_lo1 = '0;
    logic [31:0] cap_w [6];

    // TLB array: search and read ports, write on the clock edge
    always_comb begin
        bus.s1_found = 1'b0;
        bus.s1_index = '0;
        for (int i = 15; i >= 0; i--) begin
            if (tlb[i].vpn2 == bus.s1_vpn2 && (tlb[i].g || tlb[i].asid == bus.s1_asid)) begin
                bus.s1_found = 1'b1;
                bus.s1_index = 4'(i);
            end
        end
        re         = tlb[bus.r_index];
        bus.r_vpn2 = re.vpn2;
        bus.r_asid = re.asid;
        bus.r_g    = re.g;
        bus.r_pfn0 = re.pfn0;
        bus.r_pfn1 = re.pfn1;
        bus.r_c0   = re.c0;
        bus.r_c1   = re.c1;
        bus.r_d0   = re.d0;
        bus.r_d1   = re.d1;
        bus.r_v0   = re.v0;
        bus.r_v1   = re.v1;
    end

    always @(posedge clk) begin
        if (bus.we) begin
            we_cnt <= we_cnt + 1;
            tlb[bus.w_index] <= {bus.w_vpn2, bus.w_asid, bus.w_g, bus.w_pfn0, bus.w_pfn1,
                                 bus.w_c0, bus.w_c1, bus.w_d0, bus.w_d1, bus.w_v0, bus.w_v1};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] m_search(input logic [18:0] v, input logic [7:0] a);
        for (int i = 0; i < 16; i++) begin
            if (tlb[i].vpn2 == v && (tlb[i].g || tlb[i].asid == a)) return {1'b1, 4'(i)};
        end
        return 5'b0;
    endfunction

    task automatic model_mtc0(input logic [7:0] a, input logic [31:0] d);
        case (a)
            8'h00: m_index = {m_index[31], 27'b0, d[3:0]};
            8'h10: m_lo0   = d & 32'h03FF_FFFF;
            8'h18: m_lo1   = d & 32'h03FF_FFFF;
            8'h50: m_hi    = d & 32'hFFFF_E0FF;
            default: ;
        endcase
    endtask

    function automatic logic [7:0] pick_addr();
        logic [7:0] tbl [5];
        tbl = '{8'h00, 8'h10, 8'h18, 8'h50, 8'h08};
        return tbl[$urandom_range(0, 4)];
    endfunction

    // EntryHi values kept in a small VPN2/ASID space so probes hit often
    function automatic logic [31:0] rand_data(input logic [7:0] a);
        if (a == 8'h50) return {19'($urandom_range(0, 7)), 5'($urandom), 8'($urandom_range(0, 3))};
        return $urandom;
    endfunction

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        bus.mfc0_addr = a;
        #1;
        v = bus.mfc0_rdata;
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        bus.mtc0_we    = 1'b1;
        bus.mtc0_addr  = a;
        bus.mtc0_wdata = d;
        model_mtc0(a, d);
        @(negedge clk);
        bus.mtc0_we = 1'b0;
    endtask

    task automatic check_regs();
        logic [31:0] v;
        rd(8'h00, v); chk("mfc0_index", v, m_index);
        rd(8'h10, v); chk("mfc0_lo0", v, m_lo0);
        rd(8'h18, v); chk("mfc0_lo1", v, m_lo1);
        rd(8'h50, v); chk("mfc0_hi", v, m_hi);
        rd(8'h08, v); chk("mfc0_other", v, 32'h0);
        chk("s1_key", {5'b0, bus.s1_odd_page, bus.s1_vpn2, bus.s1_asid},
            {6'b0, m_hi[31:13], m_hi[7:0]});
        chk("r_index", 32'(bus.r_index), 32'(m_index[3:0]));
    endtask

    // Issue one op with optional same-cycle mtc0 and optional mtc0/op_valid while busy
    task automatic do_op(input logic [1:0] t, input bit cm, input logic [7:0] ca,
                         input logic [31:0] cd, input bit busy);
        int cnt0;
        logic [4:0] sr;
        cnt0 = we_cnt;
        chk("op_ready_idle", 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1;
        bus.op_type  = t;
        if (cm) begin
            bus.mtc0_we    = 1'b1;
            bus.mtc0_addr  = ca;
            bus.mtc0_wdata = cd;
            model_mtc0(ca, cd);
        end
        @(negedge clk);
        bus.op_valid = busy;
        bus.mtc0_we  = busy;
        if (busy) begin
            bus.mtc0_addr  = pick_addr();
            bus.mtc0_wdata = rand_data(bus.mtc0_addr);
        end
        if (t == T_RS) begin
            chk("rsv_done", {bus.op_done, bus.we, bus.op_ready}, 32'b100);
            @(negedge clk);
            bus.op_valid = 1'b0;
            bus.mtc0_we  = 1'b0;
            chk("rsv_ready", {bus.op_done, bus.we, bus.op_ready}, 32'b001);
            chk("rsv_we_cnt", we_cnt, cnt0);
            return;
        end
        chk("busy_flags", {bus.op_done, bus.we, bus.op_ready}, {29'b0, 1'b0, t == T_WI, 1'b0});
        if (t == T_WI) begin
            cap_w = '{32'(bus.w_index), 32'(bus.w_vpn2), 32'(bus.w_asid), 32'(bus.w_g),
                      32'(bus.w_pfn0), 32'(bus.w_pfn1)};
            chk("w_index", 32'(bus.w_index), 32'(m_index[3:0]));
            chk("w_hi", {5'b0, bus.w_vpn2, bus.w_asid}, {5'b0, m_hi[31:13], m_hi[7:0]});
            chk("w_g", 32'(bus.w_g), 32'(m_lo0[0] & m_lo1[0]));
            chk("w_lo0", {7'b0, bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0}, {7'b0, m_lo0[25:1]});
            chk("w_lo1", {7'b0, bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1}, {7'b0, m_lo1[25:1]});
        end
        if (t == T_P) begin
            sr = m_search(m_hi[31:13], m_hi[7:0]);
            if (sr[4]) m_index = {28'b0, sr[3:0]};
            else       m_index[31] = 1'b1;
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.mtc0_we  = 1'b0;
        if (t == T_R) begin
            re    = tlb[m_index[3:0]];
            m_hi  = {re.vpn2, 5'b0, re.asid};
            m_lo0 = {6'b0, re.pfn0, re.c0, re.d0, re.v0, re.g};
            m_lo1 = {6'b0, re.pfn1, re.c1, re.d1, re.v1, re.g};
        end
        chk("done_pulse", {bus.op_done, bus.we, bus.op_ready}, 32'b100);
        @(negedge clk);
        chk("back_idle", {bus.op_done, bus.we, bus.op_ready}, 32'b001);
        chk("we_count", we_cnt, cnt0 + ((t == T_WI) ? 1 : 0));
    endtask

    initial begin
        logic [31:0] v;
        int cnt0;
        ent_t saved;
        logic [1:0] t;
        logic [7:0] a;
        bus.op_valid   = 1'b0;
        bus.op_type    = 2'b0;
        bus.mtc0_we    = 1'b0;
        bus.mtc0_addr  = 8'h0;
        bus.mtc0_wdata = 32'h0;
        bus.mfc0_addr  = 8'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_flags", {bus.op_done, bus.we, bus.op_ready}, 32'b001);
        check_regs();

        // TLBWI of a global entry at index 3
        mtc0(8'h50, 32'h0000_2005);
        mtc0(8'h10, 32'h0000_0047);
        mtc0(8'h18, 32'h0000_0087);
        mtc0(8'h00, 32'd3);
        do_op(T_WI, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("wi_idx", cap_w[0], 32'd3);
        chk("wi_vpn2", cap_w[1], 32'd1);
        chk("wi_asid", cap_w[2], 32'd5);
        chk("wi_g", cap_w[3], 32'd1);
        chk("wi_pfn0", cap_w[4], 32'd1);
        chk("wi_pfn1", cap_w[5], 32'd2);
        check_regs();

        do_op(T_P, 1'b0, 8'h0, 32'h0, 1'b0);
        rd(8'h00, v); chk("tlbp_hit", v, 32'h0000_0003);
        mtc0(8'h50, 32'h0000_2006);
        do_op(T_P, 1'b0, 8'h0, 32'h0, 1'b0);
        rd(8'h00, v); chk("tlbp_g_hit", v, 32'h0000_0003);
        mtc0(8'h50, 32'h0000_E005);
        do_op(T_P, 1'b0, 8'h0, 32'h0, 1'b0);
        rd(8'h00, v); chk("tlbp_miss", v, 32'h8000_0003);

        mtc0(8'h00, 32'd3);
        mtc0(8'h50, 32'h0);
        do_op(T_R, 1'b0, 8'h0, 32'h0, 1'b0);
        rd(8'h50, v); chk("tlbr_hi", v, 32'h0000_2005);
        rd(8'h10, v); chk("tlbr_lo0", v, 32'h0000_0047);
        rd(8'h18, v); chk("tlbr_lo1", v, 32'h0000_0087);

        // Reserved op, same-cycle mtc0+TLBP, then busy-time mtc0 dropped
        do_op(T_RS, 1'b0, 8'h0, 32'h0, 1'b0);
        check_regs();
        do_op(T_P, 1'b1, 8'h50, 32'h0000_2005, 1'b0);
        rd(8'h00, v); chk("same_cycle_tlbp", v, 32'h0000_0003);
        do_op(T_P, 1'b0, 8'h0, 32'h0, 1'b1);
        check_regs();

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                a = pick_addr();
                mtc0(a, rand_data(a));
            end else begin
                t = 2'($urandom_range(0, 3));
                a = pick_addr();
                do_op(t, $urandom_range(0, 3) == 0, a, rand_data(a), $urandom_range(0, 2) == 0);
            end
            check_regs();
        end

        // Reset during WRITE: no commit, no done pulse, registers cleared
        mtc0(8'h00, 32'd9);
        mtc0(8'h50, 32'h0000_A00C);
        mtc0(8'h10, 32'h0000_0123);
        mtc0(8'h18, 32'h0000_0456);
        saved = tlb[9];
        cnt0 = we_cnt;
        bus.op_valid = 1'b1;
        bus.op_type  = T_WI;
        @(negedge clk);
        bus.op_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_flags", {bus.op_done, bus.we, bus.op_ready}, 32'b001);
        @(negedge clk);
        reset = 1'b0;
        m_index = '0; m_hi = '0; m_lo0 = '0; m_lo1 = '0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_quiet", {bus.op_done, bus.we, bus.op_ready}, 32'b001);
            @(negedge clk);
        end
        chk("rst_tlb_kept", 32'(tlb[9] == saved), 32'd1);
        chk("rst_no_write", we_cnt, cnt0);
        check_regs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlb_cp0_ctrl.md
TLB_CP0_CTRL -- requirements
Module: tlb_cp0_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, TLB entry count; IW = log2(TLBNUM) = 4.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports op_valid in 1, op_type in 2 (00 TLBP, 01 TLBR, 10 TLBWI, 11 reserved), op_ready out 1, op_done out 1: TLB instruction handshake.
REQ-005 SHALL have ports mtc0_we in 1, mtc0_addr in 8 ({reg[4:0],sel[2:0]}), mtc0_wdata in 32: CP0 register write.
REQ-006 SHALL have ports mfc0_addr in 8, mfc0_rdata out 32: combinational CP0 register read.
REQ-007 SHALL have search-side ports s1_vpn2 out 19, s1_odd_page out 1, s1_asid out 8, s1_found in 1, s1_index in IW.
REQ-008 SHALL have write-side ports we out 1, w_index out IW, w_vpn2 out 19, w_asid out 8, w_g out 1, w_pfn0/w_pfn1 out 20, w_c0/w_c1 out 3, w_d0/w_d1/w_v0/w_v1 out 1.
REQ-009 SHALL have read-side ports r_index out IW, and inputs r_vpn2 19, r_asid 8, r_g 1, r_pfn0/r_pfn1 20, r_c0/r_c1 3, r_d0/r_d1/r_v0/r_v1 1.

Function
REQ-010 SHALL hold CP0 registers Index {P[31], idx[IW-1:0]}, EntryHi {VPN2[31:13], ASID[7:0]}, EntryLo0/EntryLo1 {PFN[25:6], C[5:3], D[2], V[1], G[0]}; all other bits read 0.
REQ-011 SHALL decode addresses Index=0x00, EntryLo0=0x10, EntryLo1=0x18, EntryHi=0x50; other mfc0_addr return 0; mtc0 to other addresses is ignored.
REQ-012 SHALL apply mtc0 only in IDLE; mtc0_we in any other state SHALL be dropped; writes to Index update only idx (P is read-only).
REQ-013 SHALL implement FSM states IDLE, PROBE, READ, WRITE, DONE; op_ready = (state==IDLE).
REQ-014 SHALL accept an op on op_valid & op_ready: TLBP->PROBE, TLBR->READ, TLBWI->WRITE, reserved->DONE with no side effect.
REQ-015 SHALL drive s1_vpn2/s1_asid from EntryHi continuously and s1_odd_page = 0.
REQ-016 PROBE (1 cycle): at its end SHALL load Index.P = ~s1_found and Index.idx = s1_found ? s1_index : unchanged; then DONE.
REQ-017 SHALL drive r_index = Index.idx continuously; READ (1 cycle): at its end SHALL load EntryHi, EntryLo0, EntryLo1 from r_*, with G bit of both EntryLo = r_g; then DONE.
REQ-018 WRITE (1 cycle): SHALL assert we = 1 with w_index = Index.idx, w_* from EntryHi/EntryLo, w_g = EntryLo0.G & EntryLo1.G; then DONE; we SHALL be 0 in all other states.
REQ-019 DONE (1 cycle): SHALL assert op_done = 1 and return to IDLE; fixed latency: accept at cycle N, op_done at cycle N+2, op_ready again at N+3.
REQ-020 mtc0 and op accepted in the same IDLE cycle: register write SHALL complete first; the op SHALL use the updated value.
REQ-021 op_valid while not ready SHALL be ignored (no queueing); the caller holds it.

Reset
REQ-022 On reset asserted, state SHALL go to IDLE immediately; Index, EntryHi, EntryLo0, EntryLo1 SHALL be 0; op_done = 0, we = 0, op_ready = 1 after reset release.
REQ-023 Reset mid-operation SHALL abort the op with no TLB write and no op_done pulse.

Verification
REQ-024 TLBWI: mtc0 EntryHi=0x0000_2005, EntryLo0=0x0000_0047, EntryLo1=0x0000_0087, Index=3, op TLBWI -> one cycle we=1, w_index=3, w_vpn2=1, w_asid=5, w_g=1, w_pfn0=1, w_pfn1=2; op_done at N+2.
REQ-025 TLBP hit: after REQ-024, op TLBP with same EntryHi -> mfc0 Index = 0x0000_0003; change ASID to 6, G entry -> still hit.
REQ-026 TLBP miss: EntryHi VPN2=0x7 -> Index = 0x8000_0003 (P set, idx unchanged).
REQ-027 TLBR: Index=3, EntryHi cleared, op TLBR -> EntryHi=0x0000_2005, EntryLo0=0x47, EntryLo1=0x87.
REQ-028 Back-to-back ops, mtc0 while busy (dropped), reserved op_type (op_done only), reset asserted in WRITE (no we, no op_done, registers 0).
